// File: rtl/stage_rr_arbiter_pkg.sv
// Shared types, default parameters and width helper for the stage round-robin arbiter.
package stage_rr_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_BURST  = 4;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/stage_rr_arbiter_if.sv
// Requester/sink bundle for stage_rr_arbiter; master is the environment, slave the arbiter.
interface stage_rr_arbiter_if
  import stage_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int unsigned IW = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            ack;
  logic                          stage_en;
  logic [DATA_WIDTH-1:0]         stage_data;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [IW-1:0]                 grant_idx;

  modport master (
    output req, lock, data, out_ready,
    input  ack, stage_en, stage_data, out_data, out_valid, grant_idx
  );

  modport slave (
    input  req, lock, data, out_ready,
    output ack, stage_en, stage_data, out_data, out_valid, grant_idx
  );

endinterface

// File: rtl/stage_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo NUM_REQ.
module stage_rr_arbiter_rr_pick
  import stage_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IW     = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;

  assign req_dbl = {req, req};
  assign rot     = NUM_REQ'(req_dbl >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = IW'((32'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/stage_rr_arbiter_stage_reg.sv
// Enable-loaded data register stage with its own active-low async reset.
module stage_rr_arbiter_stage_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/stage_rr_arbiter.sv
// Round-robin arbiter feeding one shared register stage, with bounded locked bursts
// and valid/ready tracking towards the sink.
module stage_rr_arbiter
  import stage_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input logic               clk,
  input logic               rst,
  stage_rr_arbiter_if.slave bus
);

  localparam int unsigned IW = clog2_min1(NUM_REQ);
  localparam int unsigned BW = clog2_min1(MAX_BURST + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          valid_q, valid_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] winner;
  logic          found;
  logic          space;
  logic          issue;
  logic          stage_rst_n;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (32'(x) == NUM_REQ - 1) ? '0 : x + IW'(1);
  endfunction

  stage_rr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // While locked only the owner may be served.
  assign winner = (state_q == LOCKED) ? owner_q : pick_idx;
  assign found  = (state_q == LOCKED) ? bus.req[owner_q] : pick_found;
  assign space  = !valid_q || bus.out_ready;
  assign issue  = !rst && space && found;

  always_comb begin
    bus.ack = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.ack[k] = issue && (winner == IW'(k));
    end
  end

  always_comb begin
    bus.stage_data = bus.data[DATA_WIDTH-1:0];
    for (int k = 1; k < NUM_REQ; k++) begin
      if (issue && (winner == IW'(k))) begin
        bus.stage_data = bus.data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.stage_en  = issue;
  assign bus.out_valid = valid_q;
  assign bus.grant_idx = grant_q;

  // Next-state: arbitration pointer, burst ownership and stage occupancy.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    valid_d  = issue || (valid_q && !bus.out_ready);
    case (state_q)
      ARB: begin
        if (issue) begin
          grant_d = winner;
          if (bus.lock[winner] && (MAX_BURST > 1)) begin
            state_d = LOCKED;
            owner_d = winner;
            burst_d = BW'(1);
          end else begin
            rr_ptr_d = next_idx(winner);
          end
        end
      end
      LOCKED: begin
        if (issue) begin
          grant_d = owner_q;
          if (!bus.lock[owner_q] || (32'(burst_q) + 1 == MAX_BURST)) begin
            state_d  = ARB;
            rr_ptr_d = next_idx(owner_q);
            burst_d  = '0;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end else if (space && !bus.req[owner_q]) begin
          state_d  = ARB;
          rr_ptr_d = next_idx(owner_q);
          burst_d  = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      valid_q  <= valid_d;
    end
  end

  // Stage clears together with valid_q from the same reset.
  assign stage_rst_n = ~rst;

  stage_rr_arbiter_stage_reg #(.WIDTH(DATA_WIDTH)) u_stage (
    .clk   (clk),
    .rst_n (stage_rst_n),
    .en    (issue),
    .d     (bus.stage_data),
    .q     (bus.out_data)
  );

endmodule

// File: tb/tb_stage_rr_arbiter.sv
// Directed bench for stage_rr_arbiter: scoreboarded stage words plus ack/grant/valid checks.
module tb_stage_rr_arbiter;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] dw [4];
  logic [7:0] sb [$];

  stage_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  stage_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    for (int k = 0; k < 4; k++) if (oh[k]) return k;
    return 0;
  endfunction

  task automatic pack();
    bus.data = {dw[3], dw[2], dw[1], dw[0]};
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] l);
    bus.req  = r;
    bus.lock = l;
    for (int k = 0; k < 4; k++) dw[k] = 8'($urandom);
    pack();
  endtask

  // Called at a negedge with inputs set; checks this cycle's issue and the word it loads.
  task automatic step(input string tag, input logic [3:0] exp_ack, input int exp_grant);
    logic [7:0] w;
    #1;
    chk({tag, " ack"}, 32'(bus.ack), 32'(exp_ack));
    chk({tag, " stage_en"}, 32'(bus.stage_en), 32'(|exp_ack));
    if (exp_ack != 4'b0000) begin
      chk({tag, " stage_data"}, 32'(bus.stage_data), 32'(dw[oh2i(exp_ack)]));
      sb.push_back(dw[oh2i(exp_ack)]);
    end
    @(posedge clk);
    #1;
    if (exp_grant >= 0) chk({tag, " grant_idx"}, 32'(bus.grant_idx), 32'(exp_grant));
    if (sb.size() > 0) begin
      w = sb.pop_front();
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " out_data"}, 32'(bus.out_data), 32'(w));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_in(4'b1111, 4'b0000);

    // Reset hold
    @(posedge clk);
    #1;
    chk("rst ack", 32'(bus.ack), 32'd0);
    chk("rst stage_en", 32'(bus.stage_en), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst grant_idx", 32'(bus.grant_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full round-robin sweep
    step("rr0", 4'b0001, 0); set_in(4'b1111, 4'b0000);
    step("rr1", 4'b0010, 1); set_in(4'b1111, 4'b0000);
    step("rr2", 4'b0100, 2); set_in(4'b1111, 4'b0000);
    step("rr3", 4'b1000, 3); set_in(4'b1111, 4'b0000);
    step("rr4", 4'b0001, 0);

    // Sparse requests
    set_in(4'b1010, 4'b0000); step("sp0", 4'b0010, 1);
    set_in(4'b1010, 4'b0000); step("sp1", 4'b1000, 3);
    set_in(4'b1010, 4'b0000); step("sp2", 4'b0010, 1);

    // Backpressure holds the loaded word
    set_in(4'b0100, 4'b0000);
    dw[2] = 8'hA5;
    pack();
    step("bp_load", 4'b0100, 2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(4'b0100, 4'b0000);
      #1;
      chk("bp ack", 32'(bus.ack), 32'd0);
      chk("bp stage_en", 32'(bus.stage_en), 32'd0);
      @(posedge clk);
      #1;
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp out_data", 32'(bus.out_data), 32'hA5);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    set_in(4'b0100, 4'b0000);
    step("bp_release", 4'b0100, 2);

    // Locked burst to MAX_BURST, requester 0 starved
    set_in(4'b0001, 4'b0000); step("lk_pre", 4'b0001, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(4'b0011, 4'b0010);
      step("lk_burst", 4'b0010, 1);
    end
    set_in(4'b0011, 4'b0010); step("lk_after", 4'b0001, 0);

    // Early unlock on the second word
    set_in(4'b0100, 4'b0100); step("eu0", 4'b0100, 2);
    set_in(4'b0100, 4'b0000); step("eu1", 4'b0100, 2);
    set_in(4'b0101, 4'b0000); step("eu_arb", 4'b0001, 0);

    // Owner drops request mid-burst: one bubble
    set_in(4'b0110, 4'b0010); step("od0", 4'b0010, 1);
    set_in(4'b0100, 4'b0000); step("od_bubble", 4'b0000, 1);
    chk("od bubble out_valid", 32'(bus.out_valid), 32'd0);
    set_in(4'b0100, 4'b0000); step("od_next", 4'b0100, 2);

    // Reset in the middle of a burst
    set_in(4'b0010, 4'b0010); step("mr_lock", 4'b0010, 1);
    chk("mr pre out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr out_data", 32'(bus.out_data), 32'd0);
    chk("mr ack", 32'(bus.ack), 32'd0);
    chk("mr stage_en", 32'(bus.stage_en), 32'd0);
    chk("mr grant_idx", 32'(bus.grant_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_in(4'b1111, 4'b0000); step("mr_restart0", 4'b0001, 0);
    set_in(4'b1111, 4'b0000); step("mr_restart1", 4'b0010, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
